// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
// mem_ctrl: byte-serial memory controller between the CPU fetch/data ports
// and the 8-bit RAM/IO bus. Data port wins arbitration; each request is
// split into byte transfers and answered with a single done pulse.
// Optional feature: define MEM_CTRL_IO_THROTTLE_EN to stall writes into
// IO space (mem_a[17:16] == 2'b11) while io_buffer_full is set.
//
// state   | meaning
// S_IDLE  | waiting for a request, arbitrate and latch it
// S_READ  | issue byte addresses, capture mem_din one cycle later
// S_WRITE | drive one write byte per active cycle
// S_DONE  | pulse done of the served port with the assembled data
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [1:0]            dm_len,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [31:0]           dm_wdata,
  output logic                  dm_done,
  output logic [31:0]           dm_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_is_dm;
  logic [2:0]            r_len;
  logic [2:0]            r_iss;
  logic [2:0]            r_cap;
  logic                  r_prev_iss;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_wdata;
  logic [31:0]           r_data;

  logic                  w_start;
  logic                  w_issue;
  logic                  w_capture;
  logic                  w_wr_stall;
  logic                  w_wr_go;
  logic                  w_done_now;
  logic [2:0]            w_req_len;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_addr    = r_base + ADDR_WIDTH'(r_iss);
  assign w_start   = (r_state == S_IDLE) && rdy_in && (dm_req || if_req);
  assign w_issue   = (r_state == S_READ) && rdy_in && (r_iss < r_len);
  assign w_capture = (r_state == S_READ) && rdy_in && r_prev_iss;
  assign w_req_len = !dm_req          ? 3'd4 :
                     (dm_len == 2'b00) ? 3'd1 :
                     (dm_len == 2'b01) ? 3'd2 : 3'd4;

`ifdef MEM_CTRL_IO_THROTTLE_EN
  assign w_wr_stall = (w_addr[17:16] == 2'b11) && io_buffer_full;
`else
  logic w_unused_io;
  assign w_unused_io = io_buffer_full;
  assign w_wr_stall  = 1'b0;
`endif

  assign w_wr_go    = (r_state == S_WRITE) && rdy_in && !w_wr_stall;
  assign w_done_now = (r_state == S_DONE) && rdy_in;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a frozen cycle keeps the current state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = (dm_req && dm_we) ? S_WRITE : S_READ;
      S_READ:  if (w_capture && (r_cap + 3'd1 == r_len)) w_state_nxt = S_DONE;
      S_WRITE: if (w_wr_go && (r_iss + 3'd1 == r_len)) w_state_nxt = S_DONE;
      S_DONE:  if (rdy_in) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus and completion outputs; idle/done/frozen cycles keep the bus quiet.
  always_comb begin
    mem_a    = '0;
    mem_dout = 8'h00;
    mem_wr   = 1'b0;
    if (w_issue) mem_a = w_addr;
    if ((r_state == S_WRITE) && rdy_in) begin
      mem_a    = w_addr;
      mem_dout = r_wdata[{r_iss[1:0], 3'b000} +: 8];
      mem_wr   = w_wr_go;
    end
    if_done  = w_done_now && !r_is_dm;
    dm_done  = w_done_now && r_is_dm;
    if_inst  = if_done ? r_data : 32'h0;
    dm_rdata = dm_done ? r_data : 32'h0;
  end

  // Request latch, byte counters and read-data assembly.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_is_dm    <= 1'b0;
      r_len      <= 3'd0;
      r_iss      <= 3'd0;
      r_cap      <= 3'd0;
      r_prev_iss <= 1'b0;
      r_base     <= '0;
      r_wdata    <= 32'h0;
      r_data     <= 32'h0;
    end else if (!rdy_in) begin
      // The byte issued just before the freeze is lost; re-issue it.
      if (r_state == S_READ) begin
        r_iss      <= r_cap;
        r_prev_iss <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_is_dm    <= dm_req;
            r_base     <= dm_req ? dm_addr : if_addr;
            r_len      <= w_req_len;
            r_wdata    <= dm_wdata;
            r_data     <= 32'h0;
            r_iss      <= 3'd0;
            r_cap      <= 3'd0;
            r_prev_iss <= 1'b0;
          end
        end
        S_READ: begin
          r_prev_iss <= w_issue;
          if (w_issue) r_iss <= r_iss + 3'd1;
          if (w_capture) begin
            r_data[{r_cap[1:0], 3'b000} +: 8] <= mem_din;
            r_cap <= r_cap + 3'd1;
          end
        end
        S_WRITE: begin
          if (w_wr_go) r_iss <= r_iss + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
// Testbench for mem_ctrl: table of single requests plus hand-written
// sequences for arbitration, freeze, reset mid-write and IO throttle.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req, if_done, dm_req, dm_we, dm_done, mem_wr, io_buffer_full;
  logic [31:0] if_addr, if_inst, dm_addr, dm_wdata, dm_rdata, mem_a;
  logic [1:0]  dm_len;
  logic [7:0]  mem_din, mem_dout;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .dm_req(dm_req), .dm_we(dm_we), .dm_len(dm_len), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // RAM model: 256 KiB aliased on mem_a[17:0], read data one cycle late.
  logic [7:0] ram [0:262143];
  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] = mem_dout;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] tr_a    [0:63];
  logic        tr_wr   [0:63];
  logic [7:0]  tr_dout [0:63];
  logic        tr_zero [0:63];

  typedef struct {
    logic        is_if;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_cyc;
    logic [31:0] exp_data;
    int          exp_wr;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      logic [17:0] idx;
      idx = 18'(a + 32'(i));
      w[8*i +: 8] = ram[idx];
    end
    return w;
  endfunction

  // Drives one request starting in the current (IDLE) cycle and traces the bus.
  task automatic run_req(input logic is_if, input logic we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int frz_lo, input int frz_hi, input int rst_cyc,
                         input int io_lo, input int io_hi, input int maxc,
                         output int done_cyc, output logic [31:0] data,
                         output int other_done);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      dm_req = 1'b1; dm_we = we; dm_len = len; dm_addr = addr; dm_wdata = wdata;
    end
    done_cyc = -1; data = 32'h0; other_done = 0;
    for (int c = 0; c < maxc && done_cyc < 0; c++) begin
      rdy_in = !(c >= frz_lo && c <= frz_hi);
      io_buffer_full = (c >= io_lo && c <= io_hi);
      rst_in = (c == rst_cyc);
      if (c == rst_cyc) begin if_req = 1'b0; dm_req = 1'b0; end
      @(negedge clk_in);
      tr_a[c] = mem_a; tr_wr[c] = mem_wr; tr_dout[c] = mem_dout;
      tr_zero[c] = (mem_a == 0) && !mem_wr && (mem_dout == 0) && !if_done &&
                   !dm_done && (if_inst == 0) && (dm_rdata == 0);
      if (is_if ? dm_done : if_done) other_done++;
      if (is_if ? if_done : dm_done) begin
        done_cyc = c;
        data = is_if ? if_inst : dm_rdata;
        if_req = 1'b0; dm_req = 1'b0;
      end
      @(posedge clk_in); #1;
    end
    rdy_in = 1'b1; io_buffer_full = 1'b0; rst_in = 1'b0; if_req = 1'b0; dm_req = 1'b0;
  endtask

  function automatic int count_wr(input int last);
    int n = 0;
    for (int c = 0; c <= last && c < 64; c++) if (tr_wr[c]) n++;
    return n;
  endfunction

  initial begin
    int          dc, od, nb, wc, cnt;
    logic [31:0] dv;
    int          dm_c, if_c;
    logic [31:0] dm_v, if_v;

    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h05; ram[18'h00102] = 8'h00;
    ram[18'h00103] = 8'h00; ram[18'h00104] = 8'hA7;
    ram[18'h00200] = 8'h11; ram[18'h00201] = 8'h22; ram[18'h00202] = 8'h33;
    ram[18'h00203] = 8'h44;
    ram[18'h3FFFE] = 8'h5A; ram[18'h3FFFF] = 8'h6B; ram[18'h00000] = 8'h7C;
    ram[18'h00001] = 8'h8D;

    //            is_if we  len    addr          wdata         cyc data          wr
    vecs[0] = '{1'b1, 1'b0, 2'b11, 32'h00000100, 32'h0,        6, 32'h00000513, 0};
    vecs[1] = '{1'b0, 1'b0, 2'b00, 32'h00000202, 32'h0,        3, 32'h00000033, 0};
    vecs[2] = '{1'b0, 1'b0, 2'b01, 32'h00000201, 32'h0,        4, 32'h00003322, 0};
    vecs[3] = '{1'b0, 1'b0, 2'b10, 32'h00000200, 32'h0,        6, 32'h44332211, 0};
    vecs[4] = '{1'b0, 1'b0, 2'b11, 32'hFFFFFFFE, 32'h0,        6, 32'h8D7C6B5A, 0};
    vecs[5] = '{1'b0, 1'b1, 2'b01, 32'h00002001, 32'hDEADBEEF, 3, 32'h0000BEEF, 2};
    vecs[6] = '{1'b0, 1'b1, 2'b00, 32'h00002100, 32'h12345678, 2, 32'h00000078, 1};
    vecs[7] = '{1'b0, 1'b1, 2'b11, 32'h00002200, 32'hCAFEF00D, 5, 32'hCAFEF00D, 4};
    vecs[8] = '{1'b0, 1'b0, 2'b11, 32'h00002200, 32'h0,        6, 32'hCAFEF00D, 0};

    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0; dm_len = 2'b00;
    dm_addr = 32'h0; dm_wdata = 32'h0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset outputs zero", {31'h0, (mem_a == 0) && !mem_wr && (mem_dout == 0) &&
        !if_done && !dm_done && (if_inst == 0) && (dm_rdata == 0)}, 32'h1);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].is_if, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata,
              -1, -2, -1, -1, -2, 20, dc, dv, od);
      nb = (vecs[i].is_if || vecs[i].len[1]) ? 4 : (vecs[i].len == 2'b01 ? 2 : 1);
      chk($sformatf("v%0d done cycle", i), 32'(dc), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d other done", i), 32'(od), 32'h0);
      chk($sformatf("v%0d first addr", i), tr_a[1], vecs[i].addr);
      chk($sformatf("v%0d last addr", i), tr_a[nb], vecs[i].addr + 32'(nb - 1));
      chk($sformatf("v%0d write count", i), 32'(count_wr(dc < 0 ? 19 : dc)), 32'(vecs[i].exp_wr));
      if (vecs[i].we) begin
        chk($sformatf("v%0d ram word", i), ram_word(vecs[i].addr), vecs[i].exp_data);
        chk($sformatf("v%0d first dout", i), {24'h0, tr_dout[1]}, {24'h0, vecs[i].wdata[7:0]});
        chk($sformatf("v%0d last dout", i), {24'h0, tr_dout[nb]},
            {24'h0, 8'(vecs[i].wdata >> (8 * (nb - 1)))});
      end else begin
        chk($sformatf("v%0d read data", i), dv, vecs[i].exp_data);
      end
    end

    // Arbitration: data request wins, fetch is served right after.
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_len = 2'b00; dm_addr = 32'h100;
    dm_c = -1; if_c = -1; dm_v = 32'h0; if_v = 32'h0;
    for (int c = 0; c < 30 && if_c < 0; c++) begin
      @(negedge clk_in);
      if (dm_done && dm_c < 0) begin dm_c = c; dm_v = dm_rdata; dm_req = 1'b0; end
      if (if_done && if_c < 0) begin if_c = c; if_v = if_inst; if_req = 1'b0; end
      @(posedge clk_in); #1;
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("arb dm done cycle", 32'(dm_c), 32'd3);
    chk("arb dm data", dm_v, 32'h00000013);
    chk("arb if done cycle", 32'(if_c), 32'd10);
    chk("arb if data", if_v, 32'h44332211);

    // Freeze during cycles 3-4 of a misaligned word read.
    run_req(1'b0, 1'b0, 2'b11, 32'h101, 32'h0, 3, 4, -1, -1, -2, 30, dc, dv, od);
    cnt = 0;
    for (int c = 0; c <= 12; c++) if (tr_a[c] == 32'h102) cnt++;
    chk("freeze done cycle", 32'(dc), 32'd9);
    chk("freeze data", dv, 32'hA7000005);
    chk("freeze 0x102 issues", 32'(cnt), 32'd2);
    chk("freeze resume addr", tr_a[5], 32'h102);

    // Reset asserted in cycle 2 of a word write.
    run_req(1'b0, 1'b1, 2'b11, 32'h2300, 32'h11223344, -1, -2, 2, -1, -2, 6, dc, dv, od);
    chk("rst no done", 32'(dc), 32'hFFFFFFFF);
    chk("rst outputs zero", {31'h0, tr_zero[3]}, 32'h1);
    chk("rst cycle2 write", {31'h0, tr_wr[2]}, 32'h1);
    chk("rst ram word", ram_word(32'h2300), 32'h00003344);

    // IO throttle: buffer full in cycles 1-5 of a byte write into IO space.
    run_req(1'b0, 1'b1, 2'b00, 32'h30000, 32'h0000005C, -1, -2, -1, 1, 5, 20, dc, dv, od);
`ifdef MEM_CTRL_IO_THROTTLE_EN
    wc = 6;
    chk("thr done cycle", 32'(dc), 32'd7);
`else
    wc = 1;
    chk("thr done cycle", 32'(dc), 32'd2);
`endif
    chk("thr write count", 32'(count_wr(dc < 0 ? 19 : dc)), 32'd1);
    chk("thr write strobe", {31'h0, tr_wr[wc]}, 32'h1);
    chk("thr write addr", tr_a[wc], 32'h30000);
    chk("thr ram byte", {24'h0, ram[18'h30000]}, 32'h5C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the CPU pipeline and the 8-bit RAM/IO bus. Arbitrates between the instruction-fetch port (32-bit reads) and the data port of the MEM stage (1/2/4-byte reads and writes). Serialises each access into byte transfers on `mem_a`/`mem_dout`/`mem_wr`/`mem_din`, and returns one `done` pulse per request. It drives the cpu top-level memory pins and sits directly downstream of ifetch and mem.

## Interface
- `ADDR_WIDTH`, 32: address width of request ports and RAM bus.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, synchronous, active-high.
- `rdy_in`  in  1  global ready; low freezes the block.
- `if_req`  in  1  fetch request; held until `if_done`.
- `if_addr`  in  32  fetch address; stable while `if_req`.
- `if_done`  out  1  one-cycle pulse; `if_inst` valid.
- `if_inst`  out  32  fetched word, little-endian.
- `dm_req`  in  1  data request; held until `dm_done`.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_len`  in  2  00 byte, 01 half, 11 word; 10 is treated as word.
- `dm_addr`  in  32  data address.
- `dm_wdata`  in  32  write data; low `len` bytes used.
- `dm_done`  out  1  one-cycle pulse; read data valid / write complete.
- `dm_rdata`  out  32  read data, zero-extended (sign extension is done in mem).
- `mem_din`  in  8  RAM read byte; valid the cycle after its address.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  32  RAM byte address.
- `mem_wr`  out  1  1 = write this cycle.
- `io_buffer_full`  in  1  UART TX buffer full.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE:**
  - `dm_req` has priority over `if_req`.
  - Latch base address, length N (1/2/4) and write data. Set counters `iss`=0 and `cap`=0.
  - Go to READ or WRITE. No request: stay in IDLE.
- **READ:**
  - Each active cycle with `iss`<N: drive `mem_a`=base+`iss`, `mem_wr`=0, then `iss`++.
  - If the previous cycle was an active issue cycle, capture `mem_din` into byte `cap`, then `cap`++.
  - When `cap` reaches N, go to DONE.
- **WRITE:**
  - Each active cycle: `mem_a`=base+k, `mem_dout`=wdata byte k, `mem_wr`=1, k++.
  - After byte N-1, go to DONE.
- **DONE:**
  - Pulse the `done` of the served port, and drive `if_inst`/`dm_rdata` from the assembled register.
  - The next state is IDLE; requests are not sampled in DONE.
  - The requester must drop `req`, or present a new request, by the edge that ends DONE.
- **Address arithmetic:** base+k is modulo 2^32. Misaligned addresses are allowed. Unread upper bytes are 0.
- **rdy_in low:**
  - All registers hold and `mem_wr` is forced to 0.
  - In READ, `iss` is rewound to `cap`, so the first active cycle after the freeze re-issues base+`cap`. Bytes already captured are kept.
- **rst_in:**
  - Go to IDLE at the next edge and drop any request in flight; no `done` is produced.
  - Bytes already written stay in RAM.
  - Reset values: `if_done`=0, `dm_done`=0, `if_inst`=0, `dm_rdata`=0, `mem_a`=0, `mem_dout`=0, `mem_wr`=0.
- Outputs in IDLE/DONE: `mem_wr`=0, `mem_a`=0, `mem_dout`=0.

## Timing
- Cycle 0 is the IDLE cycle in which the request is sampled.
- Read of N bytes:
  - READ occupies cycles 1..N+1; `done` is in cycle N+2.
  - Word: `done` in cycle 6. Byte: `done` in cycle 3.
- Write of N bytes:
  - WRITE occupies cycles 1..N; `done` is in cycle N+1.
  - Word: `done` in cycle 5. Byte: `done` in cycle 2.
- Back-to-back requests: next request sampled in the cycle after DONE, so the minimum per-request overhead is 2 cycles.
- A starved fetch waits until no `dm_req` is present in an IDLE cycle.

## Configuration
- `MEM_CTRL_IO_THROTTLE_EN`
  - **Defined:** in WRITE, if `mem_a[17:16]`==2'b11 and `io_buffer_full`=1, the cycle is a stall. `mem_wr`=0 and k does not advance; the write proceeds on the first cycle with `io_buffer_full`=0.
  - **Undefined:** `io_buffer_full` is ignored and IO writes proceed at full rate.

## Test plan
- **Word fetch:** RAM[0x100..0x103]=13,05,00,00 and `if_req`, `if_addr`=0x100.
  - `mem_a` = 0x100..0x103 in cycles 1–4, `mem_wr`=0 throughout.
  - `if_done` in cycle 6 with `if_inst`=0x00000513.
- **Half write:** `dm_we`=1, `dm_len`=01, `dm_addr`=0x2001, `dm_wdata`=0xDEADBEEF.
  - Cycle 1: `mem_a`=0x2001, `mem_dout`=0xEF, `mem_wr`=1.
  - Cycle 2: `mem_a`=0x2002, `mem_dout`=0xBE, `mem_wr`=1.
  - `dm_done` in cycle 3.
- **Arbitration:** `if_req` and a byte-read `dm_req` rise in the same IDLE cycle.
  - `dm_done` in cycle 3; IF is then sampled in cycle 4 and `if_done` is in cycle 10.
- **Freeze:** word read with `rdy_in`=0 during cycles 3–4.
  - After resume, 0x102 is re-issued once.
  - `dm_rdata` equals the RAM word, and `dm_done` is delayed exactly 3 cycles versus the unfrozen case.
- **Reset mid-write:** `rst_in`=1 in cycle 2 of a word write.
  - Next cycle: IDLE, all outputs 0, no `dm_done`.
  - Only bytes 0–1 written.
- **Throttle (macro defined):** byte write to 0x30000 with `io_buffer_full`=1 for 5 cycles.
  - `mem_wr`=0 during those cycles, then one `mem_wr`=1 cycle, then `dm_done`.
  - With the macro undefined, `dm_done` is in cycle 2.
